approx_mult_err_monitor: RTL and testbench

- Downstream consumer of the 8x8 unsigned approximate multipliers (ports x, y, z).
- Takes each operand pair and its approximate 16-bit product, computes the exact product internally, and accumulates error statistics over a window of WINDOW accepted samples.
- Publishes one report per window through a valid/ready handshake.
- Used in characterisation benches and in on-chip self-test of the approximate multiplier variants.

---
 rtl/approx_mult_err_monitor_pkg.sv | 21 ++
 rtl/approx_mult_err_monitor_if.sv | 38 +++
 rtl/approx_mult_err_monitor_ed_calc.sv | 47 ++++
 rtl/approx_mult_err_monitor.sv | 132 +++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mult_err_monitor_pkg.sv
// Shared types and constants for the approximate-multiplier error monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package approx_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } mon_state_t;

  localparam int PROD_W = 16;
  localparam int OP_W   = 8;

  // Error-distance sum width: one product-width term per sample, WINDOW samples.
  function automatic int sum_w_of(input int window);
    return PROD_W + $clog2(window);
  endfunction

endpackage

// File: rtl/approx_mult_err_monitor_if.sv
// Sample input bus and report output bus of the error monitor.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on samples, rpt_valid/rpt_ready on reports.
interface approx_mult_err_monitor_if #(
  parameter int WINDOW = 256
);
  import approx_mon_pkg::*;

  localparam int CNT_W = $clog2(WINDOW) + 1;
  localparam int SUM_W = sum_w_of(WINDOW);

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_x;
  logic [OP_W-1:0]   in_y;
  logic [PROD_W-1:0] in_z;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [SUM_W-1:0]  rpt_sum_ed;
  logic [SUM_W:0]    rpt_bias;
  logic [PROD_W-1:0] rpt_max_ed;
  logic [CNT_W-1:0]  rpt_err_cnt;
  logic              busy;

  // Sample producer / report consumer side.
  modport master (
    output start, in_valid, in_x, in_y, in_z, rpt_ready,
    input  in_ready, rpt_valid, rpt_sum_ed, rpt_bias, rpt_max_ed, rpt_err_cnt, busy
  );

  // Monitor side.
  modport slave (
    input  start, in_valid, in_x, in_y, in_z, rpt_ready,
    output in_ready, rpt_valid, rpt_sum_ed, rpt_bias, rpt_max_ed, rpt_err_cnt, busy
  );

endinterface

// File: rtl/approx_mult_err_monitor_ed_calc.sv
// Stage 1: exact product, signed error d = z - exact, |d| and nonzero flag.
// Latency: 1 cycle (outputs registered on the enable edge).
// Backpressure: none; en is the accept strobe, outputs hold when en is low.
module approx_ed_calc
  import approx_mon_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [OP_W-1:0]          x,
  input  logic [OP_W-1:0]          y,
  input  logic [PROD_W-1:0]        z,
  output logic                     vld,
  output logic signed [PROD_W:0]   d,
  output logic [PROD_W-1:0]        ed,
  output logic                     ne
);

  logic [PROD_W-1:0]        exact;
  logic signed [PROD_W:0]   diff;
  logic [PROD_W-1:0]        ed_c;

  // Exact product and error terms; |d| always fits 16 bits (range -65025..65535).
  always_comb begin
    exact = PROD_W'(x) * PROD_W'(y);
    diff  = $signed({1'b0, z}) - $signed({1'b0, exact});
    ed_c  = diff[PROD_W] ? PROD_W'(-diff) : PROD_W'(diff);
  end

  // Register the terms of the accepted sample and flag them for stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      d   <= '0;
      ed  <= '0;
      ne  <= 1'b0;
    end else begin
      vld <= en;
      if (en) begin
        d  <= diff;
        ed <= ed_c;
        ne <= (diff != '0);
      end
    end
  end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Accumulates error statistics of an approximate 8x8 multiplier over WINDOW samples.
// Latency: report valid 2 cycles after the accept edge of the last sample.
// Backpressure: in_ready only in RUN; report held stable until rpt_ready.
module approx_mult_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int CNT_W  = $clog2(WINDOW) + 1,
  parameter int SUM_W  = sum_w_of(WINDOW)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  approx_mult_err_monitor_if.slave   io
);

  mon_state_t               state;
  logic [CNT_W-1:0]         sample_cnt;
  logic                     in_ready_q;
  logic                     rpt_valid_q;
  logic                     busy_q;

  logic                     accept;
  logic                     clr;

  logic                     s1_vld;
  logic signed [PROD_W:0]   s1_d;
  logic [PROD_W-1:0]        s1_ed;
  logic                     s1_ne;

  logic [SUM_W-1:0]         sum_ed;
  logic signed [SUM_W:0]    bias;
  logic [PROD_W-1:0]        max_ed;
  logic [CNT_W-1:0]         err_cnt;

  assign accept = io.in_valid & in_ready_q;
  assign clr    = (state == IDLE) & io.start;

  approx_ed_calc u_ed_calc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .x     (io.in_x),
    .y     (io.in_y),
    .z     (io.in_z),
    .vld   (s1_vld),
    .d     (s1_d),
    .ed    (s1_ed),
    .ne    (s1_ne)
  );

  // Window sequencing; handshake outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      in_ready_q  <= 1'b0;
      rpt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.start) begin
            state      <= RUN;
            sample_cnt <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            // Last sample of the window: stop accepting on this same edge.
            if (sample_cnt == CNT_W'(WINDOW - 1)) begin
              state      <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The last sample reaches the accumulators on this edge.
          state       <= REPORT;
          rpt_valid_q <= 1'b1;
        end
        REPORT: begin
          if (io.rpt_ready) begin
            state       <= IDLE;
            rpt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          rpt_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: fold each registered stage-1 result into the window statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed  <= '0;
      bias    <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      sum_ed  <= '0;
      bias    <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (s1_vld) begin
      sum_ed  <= sum_ed + SUM_W'(s1_ed);
      bias    <= bias + (SUM_W+1)'(s1_d);
      err_cnt <= err_cnt + CNT_W'(s1_ne);
      if (s1_ed > max_ed) begin
        max_ed <= s1_ed;
      end
    end
  end

  // Accumulators are frozen in REPORT, so the report reads them directly.
  assign io.in_ready    = in_ready_q;
  assign io.rpt_valid   = rpt_valid_q;
  assign io.busy        = busy_q;
  assign io.rpt_sum_ed  = sum_ed;
  assign io.rpt_bias    = bias;
  assign io.rpt_max_ed  = max_ed;
  assign io.rpt_err_cnt = err_cnt;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Bench for approx_mult_err_monitor: WINDOW=4 directed vectors plus WINDOW=256 random.
// A sample-queue model checks every report cycle; literals pin the model per vector.
// Reports are drained with rpt_ready, including a stretch of held-off cycles.
module tb_approx_mult_err_monitor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // 100 MHz clock.
  always #5 clk = ~clk;

  approx_mult_err_monitor_if #(.WINDOW(4)) a_if ();
  approx_mult_err_monitor #(.WINDOW(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (a_if)
  );

  approx_mult_err_monitor_if #(.WINDOW(256)) b_if ();
  approx_mult_err_monitor #(.WINDOW(256)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (b_if)
  );

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state: signed errors of the samples accepted in the current window.
  int mq[$];
  bit armed = 1'b0;
  int edges_after_last = 0;

  // Record every accepted sample of the WINDOW=4 instance; forget on report or reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      armed = 1'b0;
    end else begin
      if (armed) edges_after_last++;
      if (a_if.in_valid && a_if.in_ready) begin
        mq.push_back(int'(a_if.in_z) - int'(a_if.in_x) * int'(a_if.in_y));
        if (mq.size() == 4) begin
          armed = 1'b1;
          edges_after_last = 0;
        end
      end
      if (a_if.rpt_valid && a_if.rpt_ready) begin
        mq.delete();
        armed = 1'b0;
      end
    end
  end

  bit     exp_v;
  longint m_sum, m_bias, m_max, m_cnt, m_abs;

  // Compare the report against the model on every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_v = armed && (edges_after_last >= 1);
      chk("model_rpt_valid", a_if.rpt_valid, exp_v);
      if (exp_v) begin
        m_sum = 0; m_bias = 0; m_max = 0; m_cnt = 0;
        foreach (mq[i]) begin
          m_abs  = (mq[i] < 0) ? -mq[i] : mq[i];
          m_sum += m_abs;
          m_bias += mq[i];
          if (m_abs > m_max) m_max = m_abs;
          if (mq[i] != 0) m_cnt++;
        end
        chk("model_sum_ed",  a_if.rpt_sum_ed, m_sum);
        chk("model_bias",    $signed(a_if.rpt_bias), m_bias);
        chk("model_max_ed",  a_if.rpt_max_ed, m_max);
        chk("model_err_cnt", a_if.rpt_err_cnt, m_cnt);
        chk("model_in_ready_report", a_if.in_ready, 0);
      end
    end
  end

  task automatic start_win();
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int z);
    a_if.in_valid = 1'b1;
    a_if.in_x = 8'(x);
    a_if.in_y = 8'(y);
    a_if.in_z = 16'(z);
    tick();
    a_if.in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      a_if.in_x = 8'($urandom);
      a_if.in_z = 16'($urandom);
      tick();
    end
  endtask

  task automatic wait_rpt();
    for (int i = 0; i < 8; i++) begin
      if (a_if.rpt_valid) break;
      tick();
    end
    chk("rpt_arrives", a_if.rpt_valid, 1);
  endtask

  task automatic chk_rpt(input string tag, input longint s, input longint b,
                         input longint m, input longint c);
    chk({tag, "_sum_ed"},  a_if.rpt_sum_ed, s);
    chk({tag, "_bias"},    $signed(a_if.rpt_bias), b);
    chk({tag, "_max_ed"},  a_if.rpt_max_ed, m);
    chk({tag, "_err_cnt"}, a_if.rpt_err_cnt, c);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"},  a_if.in_ready, 0);
    chk({tag, "_rpt_valid"}, a_if.rpt_valid, 0);
    chk({tag, "_busy"},      a_if.busy, 0);
    chk_rpt(tag, 0, 0, 0, 0);
  endtask

  task automatic run_random();
    longint s = 0, b = 0, m = 0, c = 0, e_abs;
    int n = 0;
    int x, y, e, z, dd;
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    chk("b_busy_after_start", b_if.busy, 1);
    while (n < 256) begin
      if ($urandom_range(0, 3) == 0) begin
        b_if.in_valid = 1'b0;
        b_if.in_x = 8'($urandom);
        tick();
      end else begin
        x = int'($urandom_range(0, 255));
        y = int'($urandom_range(0, 255));
        e = x * y;
        case ($urandom_range(0, 2))
          0: z = e;
          1: z = e + int'($urandom_range(0, 40)) - 20;
          default: z = int'($urandom_range(0, 65535));
        endcase
        if (z < 0) z = 0;
        if (z > 65535) z = 65535;
        dd = z - e;
        e_abs = (dd < 0) ? -dd : dd;
        s += e_abs;
        b += dd;
        if (e_abs > m) m = e_abs;
        if (dd != 0) c++;
        b_if.in_valid = 1'b1;
        b_if.in_x = 8'(x);
        b_if.in_y = 8'(y);
        b_if.in_z = 16'(z);
        tick();
        n++;
      end
    end
    b_if.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b_if.rpt_valid) break;
      tick();
    end
    chk("b_rpt_arrives", b_if.rpt_valid, 1);
    chk("b_sum_ed",  b_if.rpt_sum_ed, s);
    chk("b_bias",    $signed(b_if.rpt_bias), b);
    chk("b_max_ed",  b_if.rpt_max_ed, m);
    chk("b_err_cnt", b_if.rpt_err_cnt, c);
    b_if.rpt_ready = 1'b1;
    tick();
    b_if.rpt_ready = 1'b0;
    chk("b_idle_after_rpt", b_if.busy, 0);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence, then the WINDOW=256 random window.
  initial begin
    a_if.start = 1'b0; a_if.in_valid = 1'b0; a_if.rpt_ready = 1'b0;
    a_if.in_x = '0; a_if.in_y = '0; a_if.in_z = '0;
    b_if.start = 1'b0; b_if.in_valid = 1'b0; b_if.rpt_ready = 1'b0;
    b_if.in_x = '0; b_if.in_y = '0; b_if.in_z = '0;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // All exact, back-to-back; rpt_ready already high before REPORT.
    start_win();
    a_if.rpt_ready = 1'b1;
    chk("t1_in_ready_run", a_if.in_ready, 1);
    send(3, 5, 15);
    send(7, 9, 63);
    send(0, 200, 0);
    send(255, 255, 65025);
    chk("t1_valid_1_after_last", a_if.rpt_valid, 0);
    chk("t1_in_ready_dropped", a_if.in_ready, 0);
    chk("t1_busy_drain", a_if.busy, 1);
    tick();
    chk("t1_valid_2_after_last", a_if.rpt_valid, 1);
    chk_rpt("t1", 0, 0, 0, 0);
    tick();
    chk("t1_valid_after_hs", a_if.rpt_valid, 0);
    chk("t1_busy_after_hs", a_if.busy, 0);
    a_if.rpt_ready = 1'b0;
    tick();

    // Mixed errors +1,-2,0,+3 with a start pulse during RUN.
    start_win();
    send(3, 5, 16);
    a_if.start = 1'b1;
    send(10, 10, 98);
    a_if.start = 1'b0;
    send(12, 12, 144);
    send(2, 50, 103);
    wait_rpt();
    chk_rpt("t2", 6, 2, 3, 3);
    a_if.rpt_ready = 1'b1;
    tick();
    a_if.rpt_ready = 1'b0;
    tick(); tick(); tick();
    chk("t2_no_second_window", a_if.busy, 0);

    // Same vectors with input gaps, then 10 cycles of report backpressure.
    start_win();
    send(3, 5, 16);   gap(2);
    send(10, 10, 98); gap(1);
    send(12, 12, 144); gap(3);
    send(2, 50, 103);
    wait_rpt();
    for (int i = 0; i < 10; i++) begin
      chk("t4_held_sum_ed", a_if.rpt_sum_ed, 6);
      chk("t4_held_bias", $signed(a_if.rpt_bias), 2);
      chk("t4_in_ready_held", a_if.in_ready, 0);
      tick();
    end
    chk_rpt("t4", 6, 2, 3, 3);
    a_if.rpt_ready = 1'b1;
    tick();
    a_if.rpt_ready = 1'b0;
    chk("t4_idle_after_hs", a_if.busy, 0);
    chk("t4_valid_after_hs", a_if.rpt_valid, 0);

    // Corner 255*255 vs 0, start held high throughout.
    a_if.start = 1'b1;
    tick();
    send(255, 255, 0);
    send(1, 1, 1);
    send(2, 2, 4);
    send(0, 0, 0);
    wait_rpt();
    chk_rpt("t3", 65025, -65025, 65025, 1);
    a_if.rpt_ready = 1'b1;
    tick();
    a_if.rpt_ready = 1'b0;
    chk("t3_idle_after_hs", a_if.busy, 0);
    tick();
    chk("t3_restart_busy", a_if.busy, 1);
    chk("t3_restart_in_ready", a_if.in_ready, 1);
    a_if.start = 1'b0;

    // Reset after 2 of 4 samples, then a clean window.
    send(1, 1, 5);
    send(2, 2, 0);
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", a_if.busy, 0);
    start_win();
    send(1, 1, 2);
    send(1, 1, 1);
    send(1, 1, 1);
    send(1, 1, 1);
    wait_rpt();
    chk_rpt("t5", 1, 1, 1, 1);
    a_if.rpt_ready = 1'b1;
    tick();
    a_if.rpt_ready = 1'b0;
    tick();

    run_random();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
